addsub_result_display: RTL and testbench
========================================

Name: addsub_result_display

Overview:
- Downstream consumer of the 4-bit adder/subtractor result (s, c4, v).
- On a load strobe, captures the result and its signed/unsigned display mode.
- Drives a 4-digit, multiplexed, active-low common-anode 7-segment display on the FPGA lab board.
- Displays the magnitude, a sign, a carry flag and an overflow flag.

Parameters:
- REFRESH_DIV, 50000: clocks per digit slot. Legal minimum is 2. Benches use 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  capture strobe; samples s, c4, v and sgn when high.
- s  in  4  adder/subtractor sum.
- c4  in  1  adder carry-out.
- v  in  1  adder overflow flag.
- sgn  in  1  1 = show s as two's complement (-8..7); 0 = show s as unsigned hex (0..F).
- an  out  4  digit enables, active low, one-hot; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point; tied 1 (off).

Behaviour:
- Capture registers: r_s, r_c4, r_v, r_sgn.
  - Loaded on any cycle with ld=1; ld pulses may be back-to-back.
  - Cleared to 0 by rst.
  - Hold their value while ld=0.
- Refresh counter cnt:
  - Runs 0..REFRESH_DIV-1 and wraps to 0.
  - digit_idx (2 bits) advances 0→1→2→3→0 on the cycle cnt==REFRESH_DIV-1; it does not otherwise change.
- an and seg are registered.
  - Each clock they load the decode of the current digit_idx and the current capture registers.
  - This gives one-cycle latency from any idx or capture change to the pins.
- Digit decode:
  - digit 0:
    - sgn=1: magnitude of r_s as two's complement. 1000 gives 8; 1001 gives 7.
    - sgn=0: hex of r_s.
  - digit 1: '-' if r_sgn=1 and r_s[3]=1, else blank.
  - digit 2: 'C' if r_c4=1, else blank.
  - digit 3: 'U' if r_v=1, else blank.
- Glyphs ({g..a}, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - '-'=0111111, 'U'=1000001, blank=1111111
- an pattern: digit k drives an[k]=0 and all other bits 1. Exactly one digit is enabled at any time after the first post-reset cycle.
- Reset (rst=1 on an edge):
  - cnt=0, digit_idx=0, capture registers=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Reset has priority over ld.
  - Reset mid-scan returns to digit 0 with no partial slot.
- First clock after rst deasserts: an=4'b1110, seg=0 glyph (1000000).
- Simultaneous ld and idx wrap/advance:
  - Both take effect in the same cycle.
  - The next cycle's seg reflects the new data for the new idx.
- Undefined combinations are not possible: every (idx, data) pair maps to a glyph or blank.

Test Plan:
- Reset check, REFRESH_DIV=4: hold rst for 3 clocks → an=1111, seg=1111111. Next clock → an=1110, seg=1000000.
- Signed subtract result 14-5: s=1001, c4=1, v=0, sgn=1, pulse ld; scan 16 clocks → per slot:
  - an=1110, seg=1111000 ('7')
  - an=1101, seg=0111111 ('-')
  - an=1011, seg=1000110 ('C')
  - an=0111, seg=1111111 (blank)
- Unsigned mode: s=1001, sgn=0, c4=0, v=0, ld → digit0=0010000 ('9'), digits 1-3 blank.
- Overflow, 7+1: s=1000, c4=0, v=1, sgn=1, ld → digit0=0000000 ('8'), digit1 '-', digit2 blank, digit3=1000001 ('U').
- Slot timing: count clocks between an transitions → exactly REFRESH_DIV (4). Digit order 0,1,2,3,0 repeats.
- Edge events:
  - ld asserted on the wrap cycle (cnt=3) with s=0101, sgn=1 → next cycle seg shows the new idx glyph from the new data.
  - rst asserted mid-slot at idx=2 → next cycle an=1111, then resumes at an=1110.

Source files
------------

// File: rtl/addsub_result_display.sv
// Captures an adder/subtractor result on ld and scans it onto a 4-digit active-low 7-segment display.
// Latency: one clock from any capture or digit change to an/seg. No backpressure: ld is always accepted.
module addsub_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] s,
    input  logic       c4,
    input  logic       v,
    input  logic       sgn,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] G_MINUS = 7'b0111111;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_C     = 7'b1000110;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    typedef struct packed {
        logic [3:0] s;
        logic       c4;
        logic       v;
        logic       sgn;
    } cap_t;

    cap_t          r_cap;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_neg;
    logic [3:0]    w_mag;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap <= '0;
        end else if (ld) begin
            r_cap <= {s, c4, v, sgn};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // 1000 negates to itself, which reads correctly as unsigned 8.
    always_comb begin
        w_neg = r_cap.sgn & r_cap.s[3];
        w_mag = w_neg ? (~r_cap.s + 4'd1) : r_cap.s;
        w_an  = ~(4'b0001 << r_idx);
        w_seg = G_BLANK;
        case (r_idx)
            2'd0: w_seg = hex_glyph(w_mag);
            2'd1: w_seg = w_neg    ? G_MINUS : G_BLANK;
            2'd2: w_seg = r_cap.c4 ? G_C     : G_BLANK;
            default: w_seg = r_cap.v ? G_U : G_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= G_BLANK;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;
endmodule

// File: tb/tb_addsub_result_display.sv
// Directed bench for addsub_result_display: a reference model pushes the expected pins each clock,
// popped and compared after the edge, plus literal per-slot checks for each scenario.
module tb_addsub_result_display;
    localparam int DIV = 4;

    localparam logic [6:0] GLY [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [6:0] G_MINUS = 7'b0111111;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst, ld, c4, v, sgn;
    logic [3:0] s;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    addsub_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .ld(ld), .s(s), .c4(c4), .v(v), .sgn(sgn),
        .an(an), .seg(seg), .dp(dp)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    out_t sb[$];
    int checks = 0;
    int failures = 0;

    int         m_cnt = 0;
    int         m_idx = 0;
    logic [3:0] m_s = '0;
    logic       m_c4 = 1'b0, m_v = 1'b0, m_sgn = 1'b0;

    function automatic logic [6:0] model_glyph(input int idx);
        int  mag;
        logic neg;
        neg = m_sgn && m_s[3];
        mag = neg ? 16 - int'(m_s) : int'(m_s);
        case (idx)
            0: return GLY[mag];
            1: return neg ? G_MINUS : G_BLANK;
            2: return m_c4 ? GLY[12] : G_BLANK;
            default: return m_v ? G_U : G_BLANK;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    // Predict the pins for the coming edge, advance the model, then compare after the edge.
    task automatic tick(input string tag);
        out_t       e, o;
        logic [3:0] ea;
        ea = 4'b0001 << m_idx;
        if (rst) e = '{4'b1111, G_BLANK, 1'b1};
        else     e = '{~ea, model_glyph(m_idx), 1'b1};
        sb.push_back(e);
        if (rst) begin
            m_cnt = 0; m_idx = 0;
            m_s = '0; m_c4 = 1'b0; m_v = 1'b0; m_sgn = 1'b0;
        end else begin
            if (ld) begin
                m_s = s; m_c4 = c4; m_v = v; m_sgn = sgn;
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        o = '{an, seg, dp};
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   tag, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
        end
    endtask

    task automatic load(input logic [3:0] ls, input logic lc4, input logic lv, input logic lsgn);
        s = ls; c4 = lc4; v = lv; sgn = lsgn; ld = 1'b1;
        tick("load");
        ld = 1'b0;
    endtask

    // Scan 16 clocks and check the last glyph seen in each of the four slots.
    task automatic scan_expect(input string tag, input logic [6:0] g0, input logic [6:0] g1,
                               input logic [6:0] g2, input logic [6:0] g3);
        logic [6:0] seen [4];
        for (int k = 0; k < 4; k++) seen[k] = 7'bx;
        for (int i = 0; i < 16; i++) begin
            tick(tag);
            case (an)
                4'b1110: seen[0] = seg;
                4'b1101: seen[1] = seg;
                4'b1011: seen[2] = seg;
                4'b0111: seen[3] = seg;
                default: ;
            endcase
        end
        chk({tag, "_d0"}, 12'(seen[0]), 12'(g0));
        chk({tag, "_d1"}, 12'(seen[1]), 12'(g1));
        chk({tag, "_d2"}, 12'(seen[2]), 12'(g2));
        chk({tag, "_d3"}, 12'(seen[3]), 12'(g3));
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] order [6];
        int         runs [6];
        int         n_tr, run, n;

        rst = 1'b1; ld = 1'b0; s = '0; c4 = 1'b0; v = 1'b0; sgn = 1'b0;

        repeat (3) tick("reset_hold");
        chk("reset_an", 12'(an), 12'(4'b1111));
        chk("reset_seg", 12'(seg), 12'(7'b1111111));
        chk("reset_dp", 12'(dp), 12'(1'b1));
        rst = 1'b0;
        tick("post_reset");
        chk("first_an", 12'(an), 12'(4'b1110));
        chk("first_seg", 12'(seg), 12'(7'b1000000));

        load(4'b1001, 1'b1, 1'b0, 1'b1);
        scan_expect("signed_sub", 7'b1111000, 7'b0111111, 7'b1000110, 7'b1111111);

        load(4'b1001, 1'b0, 1'b0, 1'b0);
        scan_expect("unsigned", 7'b0010000, 7'b1111111, 7'b1111111, 7'b1111111);

        load(4'b1000, 1'b0, 1'b1, 1'b1);
        scan_expect("overflow", 7'b0000000, 7'b0111111, 7'b1111111, 7'b1000001);

        // Slot timing and digit order.
        prev = an; n_tr = 0; run = 0;
        for (int i = 0; i < 26 && n_tr < 6; i++) begin
            tick("timing");
            run++;
            if (an !== prev) begin
                order[n_tr] = an;
                runs[n_tr] = run;
                n_tr++;
                run = 0;
                prev = an;
            end
        end
        if (n_tr < 6) begin
            timeout("timing_transitions");
        end else begin
            for (int k = 1; k < 6; k++) begin
                chk($sformatf("slot_len_%0d", k), 12'(runs[k]), 12'(DIV));
                chk($sformatf("slot_order_%0d", k), 12'(order[k]),
                    12'({order[k-1][2:0], order[k-1][3]}));
            end
        end

        // ld on the wrap from digit 3 to digit 0.
        n = 0;
        while (!(m_idx == 3 && m_cnt == DIV - 1) && n < 20) begin
            tick("seek_wrap");
            n++;
        end
        if (n >= 20) timeout("seek_wrap");
        load(4'b0101, 1'b1, 1'b1, 1'b1);
        tick("wrap_next");
        chk("wrap_an", 12'(an), 12'(4'b1110));
        chk("wrap_seg", 12'(seg), 12'(7'b0010010));
        scan_expect("wrap_scan", 7'b0010010, 7'b1111111, 7'b1000110, 7'b1000001);

        // Reset in the middle of the digit-2 slot.
        n = 0;
        while (!(m_idx == 2 && m_cnt == 1) && n < 20) begin
            tick("seek_mid");
            n++;
        end
        if (n >= 20) timeout("seek_mid");
        rst = 1'b1;
        tick("mid_rst");
        chk("mid_rst_an", 12'(an), 12'(4'b1111));
        rst = 1'b0;
        tick("mid_resume");
        chk("resume_an", 12'(an), 12'(4'b1110));
        chk("resume_seg", 12'(seg), 12'(7'b1000000));
        scan_expect("after_rst", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
